fetch_prefetch: RTL and testbench

//  Parametrised instruction-fetch stage with an OBI-style memory port, multiple outstanding

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_prefetch.sv | 180 ++++++++++++++++++
 tb/tb_fetch_prefetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: the prefetch FIFO entry and fetch FSM encoding.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            err;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO. Clear wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch with multiple outstanding OBI requests and a prefetch FIFO.
//
//  state   | meaning
//  FS_IDLE | first cycle after reset, no request yet
//  FS_RUN  | issuing sequential fetches under the credit rule
//  FS_HOLD | redirect arrived while a request was waiting for gnt; old
//          | request kept stable until granted, then addr jumps to target
module fetch_prefetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h0,
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        instr_rvalid_i,
  input  logic        writeback_change_pc,
  input  logic [31:0] writeback_next_pc,
  input  logic        alu_change_pc,
  input  logic [31:0] alu_next_pc,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] pc,
  output logic [31:0] instr_send,
  output logic        instr_err,
  output logic        clk_en
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAX_L   = CW'(MAX_OUTST);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_addr;
  logic [31:0]  r_target;
  logic         r_pend;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_discard;
  logic [31:0]  r_resp_pc;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_err;
  logic         r_clk_en;

  logic          w_redirect;
  logic [31:0]   w_target;
  logic          w_credit;
  logic          w_fire;
  logic          w_wait;
  logic [CW-1:0] w_outst_nxt;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_in;
  fetch_entry_t  w_head;
  logic [FETCH_ENTRY_W-1:0] w_fifo_rdata;

  assign w_redirect  = writeback_change_pc || alu_change_pc;
  assign w_target    = writeback_change_pc ? writeback_next_pc : alu_next_pc;
  assign w_credit    = (r_outst < MAX_L) && !w_full &&
                       (({1'b0, w_count} + {1'b0, r_outst}) < DEPTH_L);
  assign w_fire      = instr_req_o && instr_gnt_i;
  assign w_wait      = instr_req_o && !instr_gnt_i;
  assign w_outst_nxt = r_outst + CW'(w_fire) - CW'(instr_rvalid_i);
  assign w_push      = instr_rvalid_i && (r_discard == '0) && !w_redirect;
  assign w_pop       = !w_empty && !stall && !w_redirect;
  assign w_in        = '{pc: r_resp_pc, instr: instr_rdata_i, err: instr_err_i};
  assign w_head      = w_fifo_rdata;

  assign instr_addr_o = r_addr;
  assign pc           = r_pc;
  assign instr_send   = r_instr;
  assign instr_err    = r_err;
  assign clk_en       = r_clk_en;

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= FS_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and request; a request left waiting for gnt stays asserted.
  always_comb begin
    w_state_nxt = r_state;
    instr_req_o = 1'b0;
    case (r_state)
      FS_IDLE: w_state_nxt = FS_RUN;
      FS_RUN: begin
        instr_req_o = r_pend || w_credit;
        if (w_redirect && !instr_gnt_i && instr_req_o) w_state_nxt = FS_HOLD;
      end
      FS_HOLD: begin
        instr_req_o = 1'b1;
        if (instr_gnt_i) w_state_nxt = FS_RUN;
      end
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  // Request address, held redirect target and outstanding-request count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr   <= PC_RESET;
      r_target <= '0;
      r_pend   <= 1'b0;
      r_outst  <= '0;
    end else begin
      r_pend  <= w_wait;
      r_outst <= w_outst_nxt;
      if (w_redirect) begin
        if (w_wait) r_target <= w_target;
        else        r_addr   <= w_target;
      end else if (w_fire) begin
        r_addr <= (r_state == FS_HOLD) ? r_target : r_addr + 32'd4;
      end
    end
  end

  // Response side: count of stale responses to drop and PC of the next kept one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_discard <= '0;
      r_resp_pc <= PC_RESET;
    end else if (w_redirect) begin
      r_discard <= w_outst_nxt;
      r_resp_pc <= w_target;
    end else begin
      if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
      r_discard <= r_discard + CW'(w_fire && (r_state == FS_HOLD))
                             - CW'(instr_rvalid_i && (r_discard != '0));
    end
  end

  // Decode-facing registers: pop on !stall, bubble on redirect, flush or empty FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc     <= '0;
      r_instr  <= '0;
      r_err    <= 1'b0;
      r_clk_en <= 1'b0;
    end else if (w_redirect) begin
      r_clk_en <= 1'b0;
    end else if (!stall) begin
      if (!w_empty) begin
        r_pc     <= w_head.pc;
        r_instr  <= w_head.instr;
        r_err    <= w_head.err;
        r_clk_en <= !flush;
      end else begin
        r_clk_en <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_redirect),
    .i_data  (w_in),
    .o_data  (w_fifo_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Scoreboard bench for fetch_prefetch: behavioural memory, expected instruction
// stream queue filled by the stimulus side, independent output monitor.
module tb_fetch_prefetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b0;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic        writeback_change_pc = 1'b0;
  logic [31:0] writeback_next_pc = '0;
  logic        alu_change_pc = 1'b0;
  logic [31:0] alu_next_pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc;
  logic [31:0] instr_send;
  logic        instr_err;
  logic        clk_en;

  fetch_prefetch #(.PC_RESET(32'h0), .DEPTH(4), .MAX_OUTST(2)) dut (
    .clk(clk), .rstn(rstn),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i), .instr_rvalid_i(instr_rvalid_i),
    .writeback_change_pc(writeback_change_pc), .writeback_next_pc(writeback_next_pc),
    .alu_change_pc(alu_change_pc), .alu_next_pc(alu_next_pc),
    .stall(stall), .flush(flush),
    .pc(pc), .instr_send(instr_send), .instr_err(instr_err), .clk_en(clk_en)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } exp_t;
  typedef struct { logic [31:0] addr; int ready; } mem_t;

  exp_t        exp_q[$];
  mem_t        mem_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          delivered = 0;
  logic [31:0] next_pc = 32'h0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] hold_tgt = 32'h0;
  bit          hold_pend = 0;
  bit          prev_wait = 0;
  logic [31:0] prev_addr = 32'h0;
  bit          mon_on = 0;

  int          gnt_pct = 100, lat_min = 1, lat_max = 1, stall_pct = 0, redir_pct = 0;
  bit          force_stall = 0, one_wb = 0, one_alu = 0, one_flush = 0;
  logic [31:0] wb_tgt = '0, alu_tgt = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a ^ 32'hA5C3_0F13) + {a[15:0], a[31:16]};
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a[5:0] == 6'h08);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One bus cycle: memory responder, redirect/stall/flush stimulus, address model.
  task automatic step();
    bit g, rv, st, fl, wb, al;
    int sz;
    logic [31:0] tg;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (prev_wait) begin
      chk("req_stable", {31'b0, instr_req_o}, 32'd1);
      chk("addr_stable", instr_addr_o, prev_addr);
    end
    g  = ($urandom_range(99) < gnt_pct);
    st = force_stall || ($urandom_range(99) < stall_pct);
    wb = one_wb || ($urandom_range(999) < redir_pct * 10 / 2);
    al = one_alu || ($urandom_range(999) < redir_pct * 10 / 2);
    if (!one_wb && wb) wb_tgt = {20'h0, $urandom_range(1023), 2'b00};
    if (!one_alu && al) alu_tgt = {20'h0, $urandom_range(1023), 2'b00};
    fl = one_flush;
    one_wb = 0; one_alu = 0; one_flush = 0;
    sz = mem_q.size();
    rv = (sz > 0) && (mem_q[0].ready <= cyc);
    instr_gnt_i    = g;
    instr_rvalid_i = rv;
    if (rv) begin
      instr_rdata_i = mem_data(mem_q[0].addr);
      instr_err_i   = mem_err(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      instr_rdata_i = $urandom;
      instr_err_i   = 1'($urandom_range(1));
    end
    stall = st;
    flush = fl;
    writeback_change_pc = wb;
    writeback_next_pc   = wb_tgt;
    alu_change_pc       = al;
    alu_next_pc         = alu_tgt;
    if (instr_req_o && g) begin
      chk("outst_limit", {31'b0, (sz < 2)}, 32'd1);
      chk("fetch_addr", instr_addr_o, exp_addr);
      mem_q.push_back('{addr: instr_addr_o, ready: cyc + int'($urandom_range(lat_max, lat_min))});
      if (hold_pend) begin
        exp_addr  = hold_tgt;
        hold_pend = 0;
      end else begin
        exp_addr = exp_addr + 32'd4;
      end
    end
    if (wb || al) begin
      tg = wb ? wb_tgt : alu_tgt;
      if (instr_req_o && !g) begin
        hold_pend = 1;
        hold_tgt  = tg;
      end else begin
        exp_addr  = tg;
        hold_pend = 0;
      end
      exp_q.delete();
      next_pc = tg;
    end else if (fl && !st) begin
      void'(exp_q.pop_front());
    end
    prev_wait = instr_req_o && !g;
    prev_addr = instr_addr_o;
    while (exp_q.size() < 8) begin
      e.pc = next_pc; e.instr = mem_data(next_pc); e.err = mem_err(next_pc);
      exp_q.push_back(e);
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Output monitor: compares every newly presented instruction with the scoreboard.
  initial begin
    logic [31:0] p_pc, p_in;
    logic        p_err, p_ce;
    exp_t        e;
    p_pc = '0; p_in = '0; p_err = 1'b0; p_ce = 1'b0;
    wait (mon_on);
    forever begin
      @(posedge clk);
      #1;
      if (writeback_change_pc || alu_change_pc) begin
        chk("redirect_bubble", {31'b0, clk_en}, 32'd0);
      end else if (stall) begin
        chk("stall_hold_pc", pc, p_pc);
        chk("stall_hold_instr", instr_send, p_in);
        chk("stall_hold_en", {31'b0, clk_en}, {31'b0, p_ce});
      end else if (flush) begin
        chk("flush_bubble", {31'b0, clk_en}, 32'd0);
      end else if (clk_en) begin
        delivered++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected actual pc=%h required=no output", pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", pc, e.pc);
          chk("out_instr", instr_send, e.instr);
          chk("out_err", {31'b0, instr_err}, {31'b0, e.err});
        end
      end
      p_pc = pc; p_in = instr_send; p_err = instr_err; p_ce = clk_en;
    end
  end

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'b0, instr_req_o}, 32'd0);
    chk("rst_addr", instr_addr_o, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr_send, 32'h0);
    chk("rst_err", {31'b0, instr_err}, 32'd0);
    chk("rst_clk_en", {31'b0, clk_en}, 32'd0);
    rstn = 1'b1;
    mon_on = 1;

    // first request, then gnt withheld for three cycles
    step();
    chk("first_req", {31'b0, instr_req_o}, 32'd1);
    gnt_pct = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gnt_wait_req", {31'b0, instr_req_o}, 32'd1);
      chk("gnt_wait_addr", instr_addr_o, 32'h4);
    end

    // back-to-back streaming (covers err at 0x8)
    gnt_pct = 100;
    d0 = delivered;
    run(20);
    chk("stream_count", {31'b0, (delivered - d0 >= 14)}, 32'd1);

    // flush kills one instruction in steady streaming
    one_flush = 1;
    step();
    run(6);

    // redirect with long-latency responses outstanding
    lat_min = 3; lat_max = 3;
    run(8);
    one_alu = 1; alu_tgt = 32'h100;
    step();
    d0 = delivered;
    run(15);
    chk("redir_resume", {31'b0, (delivered > d0)}, 32'd1);
    lat_min = 1; lat_max = 1;
    run(4);

    // long stall: fetch must stop on credit
    force_stall = 1;
    run(10);
    chk("stall_req_off", {31'b0, instr_req_o}, 32'd0);
    force_stall = 0;
    run(12);

    // simultaneous writeback and alu redirect
    one_wb = 1; wb_tgt = 32'h80;
    one_alu = 1; alu_tgt = 32'h200;
    step();
    run(15);

    // randomised traffic
    gnt_pct = 70; lat_min = 1; lat_max = 3; stall_pct = 20; redir_pct = 6;
    run(600);
    gnt_pct = 100; stall_pct = 0; redir_pct = 0;
    d0 = delivered;
    run(30);
    chk("drain_count", {31'b0, (delivered - d0 >= 10)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
